tr_step_scheduler: RTL and testbench

- Sequences the stepper drive for the table-tracking loop.
- Captures ADC position samples and computes the error against the table target.
- Selects the step period by error zone and applies deadzone hysteresis.
- Emits timed step pulses, enforcing a direction-setup gap before any reversal; it is the single owner of drv_step/drv_dir/drv_SM.

---
 rtl/tr_pkg.sv | 33 +++
 rtl/tr_step_scheduler_if.sv | 36 +++
 rtl/tr_period_sel.sv | 48 ++++
 rtl/tr_step_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tr_step_scheduler.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tr_pkg.sv
// Shared types and default constants for the table-tracking step scheduler.
//   tr_state_e : scheduler FSM states (also exported on the debug state port)
//   tr_zone_e  : error zone that selects the step period
//   TR_*       : default parameter values used by the RTL modules
package tr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVAL    = 3'd1,
    SETTLE  = 3'd2,
    STEP_HI = 3'd3,
    STEP_LO = 3'd4,
    HOLD    = 3'd5
  } tr_state_e;

  typedef enum logic [1:0] {
    ZONE_SLOW = 2'd0,
    ZONE_MID  = 2'd1,
    ZONE_FAST = 2'd2
  } tr_zone_e;

  localparam int TR_WIDTH_IN  = 12;
  localparam int TR_PER_W     = 17;
  localparam int TR_P_FAST    = 800;
  localparam int TR_P_MID     = 39600;
  localparam int TR_P_SLOW    = 80000;
  localparam int TR_PULSE_W   = 100;
  localparam int TR_DIR_SETUP = 250;
  localparam int TR_DEADZONE  = 14;
  localparam int TR_CONST     = 0;
  localparam int TR_POS_W     = 16;

endpackage

// File: rtl/tr_step_scheduler_if.sv
// Bus between the tracking controller and the step scheduler.
//   Controller -> scheduler: enable, data_valid, x, x0, dx1, dx2
//   Scheduler -> controller: drv_step, drv_dir, drv_SM, pos, step_done, state
// Handshake: data_valid is a one-cycle strobe with no ready; the scheduler
// always accepts x/x0 on the cycle data_valid is high (there is no backpressure).
// step_done is a one-cycle strobe on every drv_step falling edge.
// state is the scheduler FSM state, exported for debug and checkers.
interface tr_step_scheduler_if
  import tr_pkg::*;
#(
  parameter int WIDTH_IN = TR_WIDTH_IN,
  parameter int POS_W    = TR_POS_W
);
  logic                enable;
  logic                data_valid;
  logic [WIDTH_IN-1:0] x;
  logic [WIDTH_IN-1:0] x0;
  logic [WIDTH_IN-1:0] dx1;
  logic [WIDTH_IN-1:0] dx2;
  logic                drv_step;
  logic                drv_dir;
  logic                drv_SM;
  logic [POS_W-1:0]    pos;
  logic                step_done;
  tr_state_e           state;

  modport master (
    output enable, data_valid, x, x0, dx1, dx2,
    input  drv_step, drv_dir, drv_SM, pos, step_done, state
  );

  modport slave (
    input  enable, data_valid, x, x0, dx1, dx2,
    output drv_step, drv_dir, drv_SM, pos, step_done, state
  );
endinterface

// File: rtl/tr_period_sel.sv
// Combinational error and period selection.
//   x, x0    : registered position sample and table target
//   dx1, dx2 : slow/mid and mid/fast zone boundaries (dx1 < dx2)
//   dx       : |x - x0|
//   new_dir  : 1 when x <= x0 (motor must move so x increases)
//   period   : step period in clk cycles for the current error zone
module tr_period_sel
  import tr_pkg::*;
#(
  parameter int WIDTH_IN = TR_WIDTH_IN,
  parameter int PER_W    = TR_PER_W,
  parameter int P_FAST   = TR_P_FAST,
  parameter int P_MID    = TR_P_MID,
  parameter int P_SLOW   = TR_P_SLOW
) (
  input  logic [WIDTH_IN-1:0] x,
  input  logic [WIDTH_IN-1:0] x0,
  input  logic [WIDTH_IN-1:0] dx1,
  input  logic [WIDTH_IN-1:0] dx2,
  output logic [WIDTH_IN-1:0] dx,
  output logic                new_dir,
  output logic [PER_W-1:0]    period
);

  tr_zone_e zone;

  // Subtract the smaller from the larger so the magnitude never wraps.
  assign new_dir = (x <= x0);
  assign dx      = new_dir ? (x0 - x) : (x - x0);

  always_comb begin
    zone = ZONE_SLOW;
    if (dx >= dx2) begin
      zone = ZONE_FAST;
    end else if (dx >= dx1) begin
      zone = ZONE_MID;
    end
  end

  always_comb begin
    case (zone)
      ZONE_FAST: period = PER_W'(P_FAST);
      ZONE_MID:  period = PER_W'(P_MID);
      default:   period = PER_W'(P_SLOW);
    endcase
  end

endmodule

// File: rtl/tr_step_scheduler.sv
// Stepper drive sequencer for the table-tracking loop.
// Captures ADC samples, picks a step period from the error zone, and emits
// timed step pulses with a direction-setup gap before any reversal. This block
// is the only driver of drv_step / drv_dir / drv_SM.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : tr_step_scheduler_if slave (enable, sample strobe/data, zone bounds in;
//         drv_step, drv_dir, drv_SM, pos, step_done, debug state out)
module tr_step_scheduler
  import tr_pkg::*;
#(
  parameter int WIDTH_IN  = TR_WIDTH_IN,
  parameter int PER_W     = TR_PER_W,
  parameter int P_FAST    = TR_P_FAST,
  parameter int P_MID     = TR_P_MID,
  parameter int P_SLOW    = TR_P_SLOW,
  parameter int PULSE_W   = TR_PULSE_W,
  parameter int DIR_SETUP = TR_DIR_SETUP,
  parameter int DEADZONE  = TR_DEADZONE,
  parameter int CONST     = TR_CONST,
  parameter int POS_W     = TR_POS_W
) (
  input logic                 clk,
  input logic                 rst,
  tr_step_scheduler_if.slave  bus
);

  logic [WIDTH_IN-1:0] x_q;
  logic [WIDTH_IN-1:0] x0_q;
  logic                samp_vld;
  logic [WIDTH_IN-1:0] dx;
  logic                new_dir;
  logic [PER_W-1:0]    period;

  tr_state_e           state;
  logic [PER_W-1:0]    cnt;     // cycles since entering SETTLE or since the step rise
  logic [PER_W-1:0]    per_n;   // period latched at the rise; fixed for the whole step
  logic                drv_step_q;
  logic                drv_dir_q;
  logic                drv_sm_q;
  logic [POS_W-1:0]    pos_q;
  logic                step_done_q;

  // Sample register. A capture arriving mid-step only affects the next EVAL,
  // and a capture coinciding with EVAL is seen one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      x0_q     <= '0;
      samp_vld <= 1'b0;
    end else if (bus.data_valid) begin
      x_q      <= bus.x;
      x0_q     <= bus.x0;
      samp_vld <= 1'b1;
    end
  end

  tr_period_sel #(
    .WIDTH_IN (WIDTH_IN),
    .PER_W    (PER_W),
    .P_FAST   (P_FAST),
    .P_MID    (P_MID),
    .P_SLOW   (P_SLOW)
  ) u_period_sel (
    .x       (x_q),
    .x0      (x0_q),
    .dx1     (bus.dx1),
    .dx2     (bus.dx2),
    .dx      (dx),
    .new_dir (new_dir),
    .period  (period)
  );

  // Step timing, counted from the rise (cnt = 0 on the first high cycle):
  //   STEP_HI  cnt 0 .. PULSE_W-1   -> PULSE_W high cycles
  //   STEP_LO  cnt PULSE_W .. N-2
  //   EVAL     one cycle
  // so consecutive rises with unchanged direction are exactly N cycles apart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      per_n       <= '0;
      drv_step_q  <= 1'b0;
      drv_dir_q   <= 1'b0;
      drv_sm_q    <= 1'b0;
      pos_q       <= '0;
      step_done_q <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      if (!bus.enable && state != STEP_HI) begin
        // A running pulse is always completed; everything else stops at once.
        state    <= IDLE;
        drv_sm_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            drv_sm_q <= 1'b0;
            if (samp_vld) state <= EVAL;
          end
          EVAL: begin
            cnt <= '0;
            if (dx <= WIDTH_IN'(CONST)) begin
              state    <= HOLD;
              drv_sm_q <= 1'b0;
            end else if (new_dir != drv_dir_q) begin
              drv_dir_q <= new_dir;
              drv_sm_q  <= 1'b1;
              state     <= SETTLE;
            end else begin
              drv_sm_q   <= 1'b1;
              drv_step_q <= 1'b1;
              per_n      <= period;
              state      <= STEP_HI;
            end
          end
          SETTLE: begin
            cnt <= cnt + PER_W'(1);
            if (cnt == PER_W'(DIR_SETUP - 1)) state <= EVAL;
          end
          STEP_HI: begin
            cnt <= cnt + PER_W'(1);
            if (cnt == PER_W'(PULSE_W - 1)) begin
              drv_step_q  <= 1'b0;
              step_done_q <= 1'b1;
              pos_q       <= drv_dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
              if (bus.enable) begin
                state <= STEP_LO;
              end else begin
                state    <= IDLE;
                drv_sm_q <= 1'b0;
              end
            end
          end
          STEP_LO: begin
            cnt <= cnt + PER_W'(1);
            if (cnt == per_n - PER_W'(2)) state <= EVAL;
          end
          HOLD: begin
            // dx only changes on a capture; leaving needs the wider DEADZONE
            // threshold, which gives hysteresis against the CONST stop point.
            drv_sm_q <= 1'b0;
            if (dx >= WIDTH_IN'(DEADZONE)) state <= EVAL;
          end
          default: begin
            state    <= IDLE;
            drv_sm_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.drv_step  = drv_step_q;
  assign bus.drv_dir   = drv_dir_q;
  assign bus.drv_SM    = drv_sm_q;
  assign bus.pos       = pos_q;
  assign bus.step_done = step_done_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_tr_step_scheduler.sv
// Directed testbench for tr_step_scheduler. P_MID and P_SLOW are scaled down
// (3960 / 8000) to keep the run short; all other parameters are defaults.
module tb_tr_step_scheduler;
  import tr_pkg::*;

  localparam int PULSE_W   = 100;
  localparam int DIR_SETUP = 250;
  localparam int P_FAST    = 800;
  localparam int P_MID     = 3960;
  localparam int P_SLOW    = 8000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tr_step_scheduler_if #(.WIDTH_IN(12), .POS_W(16)) ifc ();

  tr_step_scheduler #(
    .P_MID  (P_MID),
    .P_SLOW (P_SLOW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];     // expected pos after each completed step, in order
  logic [15:0] exp_pos;
  int          t_dv;
  int          r_prev;

  // ---------------- driver / wait tasks ----------------
  task automatic send_sample(input logic [11:0] xv, input logic [11:0] x0v);
    @(negedge clk);
    ifc.x          = xv;
    ifc.x0         = x0v;
    ifc.data_valid = 1'b1;
    t_dv           = cyc;
    @(negedge clk);
    ifc.data_valid = 1'b0;
  endtask

  // Wait until drv_step equals lvl at a negedge; t is the cycle stamp.
  task automatic wait_step(input logic lvl, input int budget, input string tag, output int t);
    bit ok;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (ifc.drv_step === lvl) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: drv_step never reached %0b within %0d cycles", tag, lvl, budget);
    end
  endtask

  task automatic count_rises(input int cycles, output int n);
    logic prev;
    prev = ifc.drv_step;
    n    = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ifc.drv_step === 1'b1 && prev !== 1'b1) n++;
      prev = ifc.drv_step;
    end
  endtask

  function automatic logic [15:0] next_exp_pos();
    if (exp_q.size() == 0) return 16'hDEAD;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    ifc.enable = 1'b0; ifc.data_valid = 1'b0;
    ifc.x = '0; ifc.x0 = '0; ifc.dx1 = 12'd10; ifc.dx2 = 12'd100;
    repeat (3) @(negedge clk);
    checks++; if (ifc.drv_step !== 1'b0) begin failures++; $display("FAIL reset_step: got %0b expected 0", ifc.drv_step); end
    checks++; if (ifc.drv_dir !== 1'b0) begin failures++; $display("FAIL reset_dir: got %0b expected 0", ifc.drv_dir); end
    checks++; if (ifc.drv_SM !== 1'b0) begin failures++; $display("FAIL reset_sm: got %0b expected 0", ifc.drv_SM); end
    checks++; if (ifc.pos !== 16'h0000) begin failures++; $display("FAIL reset_pos: got %0h expected 0", ifc.pos); end
    checks++; if (ifc.step_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", ifc.step_done); end
    checks++; if (ifc.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", ifc.state, IDLE); end
    rst = 1'b1;
    ifc.enable = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (ifc.state !== IDLE) begin failures++; $display("FAIL idle_no_sample: got %0d expected %0d", ifc.state, IDLE); end
  endtask

  task automatic test_fast_zone();
    int r1, r2, r3, f;
    send_sample(12'd1000, 12'd800);
    wait_step(1'b1, 50, "fast_r1", r1);
    checks++; if (r1 - t_dv !== 3) begin failures++; $display("FAIL fast_latency: got %0d expected 3", r1 - t_dv); end
    checks++; if (ifc.drv_dir !== 1'b0) begin failures++; $display("FAIL fast_dir: got %0b expected 0", ifc.drv_dir); end
    checks++; if (ifc.drv_SM !== 1'b1) begin failures++; $display("FAIL fast_sm: got %0b expected 1", ifc.drv_SM); end
    wait_step(1'b0, 200, "fast_f1", f);
    checks++; if (f - r1 !== PULSE_W) begin failures++; $display("FAIL fast_width: got %0d expected %0d", f - r1, PULSE_W); end
    checks++; if (ifc.step_done !== 1'b1) begin failures++; $display("FAIL fast_done: got %0b expected 1", ifc.step_done); end
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL fast_pos1: got %0h expected %0h", ifc.pos, exp_pos); end
    @(negedge clk);
    checks++; if (ifc.step_done !== 1'b0) begin failures++; $display("FAIL fast_done_once: got %0b expected 0", ifc.step_done); end
    checks++; if (ifc.state !== STEP_LO) begin failures++; $display("FAIL fast_steplo: got %0d expected %0d", ifc.state, STEP_LO); end
    wait_step(1'b1, 1000, "fast_r2", r2);
    checks++; if (r2 - r1 !== P_FAST) begin failures++; $display("FAIL fast_period1: got %0d expected %0d", r2 - r1, P_FAST); end
    wait_step(1'b0, 200, "fast_f2", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL fast_pos2: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 1000, "fast_r3", r3);
    checks++; if (r3 - r2 !== P_FAST) begin failures++; $display("FAIL fast_period2: got %0d expected %0d", r3 - r2, P_FAST); end
    r_prev = r3;
  endtask

  task automatic test_slow_then_stop();
    int r4, r5, f, h;
    bit found;
    send_sample(12'd805, 12'd800);   // mid-pulse capture: running period unchanged
    wait_step(1'b0, 200, "slow_f3", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL slow_pos3: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 1000, "slow_r4", r4);
    checks++; if (r4 - r_prev !== P_FAST) begin failures++; $display("FAIL slow_unaltered: got %0d expected %0d", r4 - r_prev, P_FAST); end
    wait_step(1'b0, 200, "slow_f4", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL slow_pos4: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 9000, "slow_r5", r5);
    checks++; if (r5 - r4 !== P_SLOW) begin failures++; $display("FAIL slow_period: got %0d expected %0d", r5 - r4, P_SLOW); end
    send_sample(12'd800, 12'd800);
    wait_step(1'b0, 200, "slow_f5", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL slow_pos5: got %0h expected %0h", ifc.pos, exp_pos); end
    found = 1'b0; h = 0;
    for (int i = 0; i < 9000 && !found; i++) begin
      @(negedge clk);
      if (ifc.state === HOLD) begin found = 1'b1; h = cyc; end
    end
    checks++; if (!found || h - r5 !== P_SLOW) begin failures++; $display("FAIL hold_entry: got %0d expected %0d", h - r5, P_SLOW); end
    checks++; if (ifc.drv_SM !== 1'b0) begin failures++; $display("FAIL hold_sm: got %0b expected 0", ifc.drv_SM); end
  endtask

  task automatic test_deadzone();
    int n, r1, r2, f;
    send_sample(12'd810, 12'd800);   // dx=10 < DEADZONE
    count_rises(100, n);
    checks++; if (n !== 0) begin failures++; $display("FAIL dz_rises: got %0d expected 0", n); end
    checks++; if (ifc.state !== HOLD) begin failures++; $display("FAIL dz_state: got %0d expected %0d", ifc.state, HOLD); end
    send_sample(12'd814, 12'd800);   // dx=14 == DEADZONE, mid zone
    wait_step(1'b1, 50, "dz_r1", r1);
    checks++; if (r1 - t_dv !== 3) begin failures++; $display("FAIL dz_latency: got %0d expected 3", r1 - t_dv); end
    checks++; if (ifc.drv_dir !== 1'b0) begin failures++; $display("FAIL dz_dir: got %0b expected 0", ifc.drv_dir); end
    wait_step(1'b0, 200, "dz_f1", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL dz_pos: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 5000, "dz_r2", r2);
    checks++; if (r2 - r1 !== P_MID) begin failures++; $display("FAIL mid_period: got %0d expected %0d", r2 - r1, P_MID); end
    r_prev = r2;
  endtask

  task automatic test_reversal();
    int r3, r4, r5, r6, f, td;
    bit found;
    send_sample(12'd1000, 12'd800);
    wait_step(1'b0, 200, "rev_f2", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL rev_pos_a: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 5000, "rev_r3", r3);
    checks++; if (r3 - r_prev !== P_MID) begin failures++; $display("FAIL rev_mid_kept: got %0d expected %0d", r3 - r_prev, P_MID); end
    wait_step(1'b0, 200, "rev_f3", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL rev_pos_b: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 1000, "rev_r4", r4);
    checks++; if (r4 - r3 !== P_FAST) begin failures++; $display("FAIL rev_fast: got %0d expected %0d", r4 - r3, P_FAST); end
    send_sample(12'd600, 12'd800);
    wait_step(1'b0, 200, "rev_f4", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL rev_pos_c: got %0h expected %0h", ifc.pos, exp_pos); end
    found = 1'b0; td = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ifc.drv_dir === 1'b1) begin found = 1'b1; td = cyc; end
    end
    checks++; if (!found || td - r4 !== P_FAST) begin failures++; $display("FAIL rev_dir_time: got %0d expected %0d", td - r4, P_FAST); end
    checks++; if (ifc.state !== SETTLE || ifc.drv_SM !== 1'b1 || ifc.drv_step !== 1'b0) begin
      failures++; $display("FAIL rev_settle: got state=%0d sm=%0b step=%0b expected %0d/1/0", ifc.state, ifc.drv_SM, ifc.drv_step, SETTLE);
    end
    wait_step(1'b1, 400, "rev_r5", r5);
    checks++; if (r5 - td !== DIR_SETUP + 1) begin failures++; $display("FAIL rev_setup_gap: got %0d expected %0d", r5 - td, DIR_SETUP + 1); end
    wait_step(1'b0, 200, "rev_f5", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL rev_pos_inc: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 1000, "rev_r6", r6);
    checks++; if (r6 - r5 !== P_FAST) begin failures++; $display("FAIL rev_period: got %0d expected %0d", r6 - r5, P_FAST); end
    r_prev = r6;
  endtask

  task automatic test_enable_drop();
    int r7, f, n;
    wait_step(1'b0, 200, "en_f6", f);
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL en_pos_a: got %0h expected %0h", ifc.pos, exp_pos); end
    wait_step(1'b1, 1000, "en_r7", r7);
    checks++; if (r7 - r_prev !== P_FAST) begin failures++; $display("FAIL en_period: got %0d expected %0d", r7 - r_prev, P_FAST); end
    repeat (39) @(negedge clk);
    ifc.enable = 1'b0;              // during cycle 40 of the pulse
    wait_step(1'b0, 200, "en_fall", f);
    checks++; if (f - r7 !== PULSE_W) begin failures++; $display("FAIL en_width: got %0d expected %0d", f - r7, PULSE_W); end
    checks++; if (ifc.step_done !== 1'b1) begin failures++; $display("FAIL en_done: got %0b expected 1", ifc.step_done); end
    exp_pos = next_exp_pos();
    checks++; if (ifc.pos !== exp_pos) begin failures++; $display("FAIL en_pos_b: got %0h expected %0h", ifc.pos, exp_pos); end
    checks++; if (ifc.state !== IDLE || ifc.drv_SM !== 1'b0) begin
      failures++; $display("FAIL en_idle: got state=%0d sm=%0b expected %0d/0", ifc.state, ifc.drv_SM, IDLE);
    end
    count_rises(1000, n);
    checks++; if (n !== 0) begin failures++; $display("FAIL en_no_rise: got %0d expected 0", n); end
    checks++; if (ifc.drv_dir !== 1'b1) begin failures++; $display("FAIL en_dir_hold: got %0b expected 1", ifc.drv_dir); end
  endtask

  task automatic test_async_reset();
    int r, t_en, n;
    @(negedge clk);
    ifc.enable = 1'b1;
    t_en = cyc;
    wait_step(1'b1, 50, "ar_rise", r);
    checks++; if (r - t_en !== 2) begin failures++; $display("FAIL ar_latency: got %0d expected 2", r - t_en); end
    repeat (20) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (ifc.drv_step !== 1'b0 || ifc.drv_SM !== 1'b0) begin
      failures++; $display("FAIL ar_outputs: got step=%0b sm=%0b expected 0/0", ifc.drv_step, ifc.drv_SM);
    end
    checks++; if (ifc.pos !== 16'h0000) begin failures++; $display("FAIL ar_pos: got %0h expected 0", ifc.pos); end
    checks++; if (ifc.state !== IDLE) begin failures++; $display("FAIL ar_state: got %0d expected %0d", ifc.state, IDLE); end
    @(negedge clk);
    rst = 1'b1;
    count_rises(200, n);
    checks++; if (n !== 0 || ifc.state !== IDLE) begin
      failures++; $display("FAIL ar_stay_idle: got rises=%0d state=%0d expected 0/%0d", n, ifc.state, IDLE);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    // pos after each completed step: 5 down (fast/slow), 4 down (mid/fast),
    // then 3 up after the reversal.
    exp_q = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA,
              16'hFFF9, 16'hFFF8, 16'hFFF7, 16'hFFF8, 16'hFFF9, 16'hFFFA};
    test_reset();
    test_fast_zone();
    test_slow_then_stop();
    test_deadzone();
    test_reversal();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
